// File: rtl/alu_pkg.sv
// alu_pkg: shared constants, FSM state type and instruction field layout for alu_ctrl.
// ALU_CTRL_ZFLAG_EN widens the result flags with a zero bit.
`default_nettype none

package alu_pkg;

  localparam logic [1:0] C_OP_ADD = 2'b00;
  localparam logic [1:0] C_OP_SUB = 2'b01;
  localparam logic [1:0] C_OP_AND = 2'b10;
  localparam logic [1:0] C_OP_OR  = 2'b11;

  // Instruction layout: {op[7:6], rd[5:4], rs1[3:2], rs2[1:0]}
  localparam int C_OP_LSB  = 6;
  localparam int C_RD_LSB  = 4;
  localparam int C_RS1_LSB = 2;
  localparam int C_RS2_LSB = 0;

  localparam int C_DATA_W = 8;

`ifdef ALU_CTRL_ZFLAG_EN
  localparam int C_FLAG_W = 3;
`else
  localparam int C_FLAG_W = 2;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPRD = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Carry-out only means something for add, borrow only for sub.
  function automatic logic [1:0] mask_flags(input logic [1:0] op,
                                            input logic       ovf,
                                            input logic       brw);
    logic f_ovf;
    logic f_brw;
    f_ovf = (op == C_OP_ADD) & ovf;
    f_brw = (op == C_OP_SUB) & brw;
    return {f_brw, f_ovf};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: instruction, preload, ALU and result bundle of alu_ctrl.
// Flag width follows ALU_CTRL_ZFLAG_EN through alu_pkg.
`default_nettype none

interface alu_ctrl_if;
  import alu_pkg::*;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [7:0]            instr;

  logic                  ld_valid;
  logic [1:0]            ld_addr;
  logic [C_DATA_W-1:0]   ld_data;

  logic [C_DATA_W-1:0]   alu_a;
  logic [C_DATA_W-1:0]   alu_b;
  logic [1:0]            alu_sel;
  logic [C_DATA_W-1:0]   alu_y;
  logic                  alu_ovf;
  logic                  alu_brw;

  logic                  res_valid;
  logic                  res_ready;
  logic [C_DATA_W-1:0]   res_data;
  logic [C_FLAG_W-1:0]   res_flags;

  modport slave (
    input  instr_valid, instr, ld_valid, ld_addr, ld_data,
    input  alu_y, alu_ovf, alu_brw, res_ready,
    output instr_ready, alu_a, alu_b, alu_sel,
    output res_valid, res_data, res_flags
  );

  modport master (
    output instr_valid, instr, ld_valid, ld_addr, ld_data,
    output alu_y, alu_ovf, alu_brw, res_ready,
    input  instr_ready, alu_a, alu_b, alu_sel,
    input  res_valid, res_data, res_flags
  );

endinterface

`default_nettype wire

// File: rtl/alu_regfile.sv
// alu_regfile: 4x8 register file, two async read ports, one write path where
// the instruction writeback overrides a preload aimed at the same register.
`default_nettype none

module alu_regfile
  import alu_pkg::*;
(
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                i_wb_en,
  input  wire logic [1:0]          i_wb_addr,
  input  wire logic [C_DATA_W-1:0] i_wb_data,
  input  wire logic                i_ld_en,
  input  wire logic [1:0]          i_ld_addr,
  input  wire logic [C_DATA_W-1:0] i_ld_data,
  input  wire logic [1:0]          i_ra_addr,
  output logic      [C_DATA_W-1:0] o_ra_data,
  input  wire logic [1:0]          i_rb_addr,
  output logic      [C_DATA_W-1:0] o_rb_data
);

  logic [C_DATA_W-1:0] r_mem [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i_wb_en && (i_wb_addr == 2'(i))) begin
          r_mem[i] <= i_wb_data;
        end else if (i_ld_en && (i_ld_addr == 2'(i))) begin
          r_mem[i] <= i_ld_data;
        end
      end
    end
  end

  assign o_ra_data = r_mem[i_ra_addr];
  assign o_rb_data = r_mem[i_rb_addr];

endmodule

`default_nettype wire

// File: rtl/alu_ctrl.sv
// alu_ctrl: sequences one instruction through an external combinational ALU
// (IDLE->OPRD->EXEC->DONE). Define ALU_CTRL_ZFLAG_EN for the zero result flag.
`default_nettype none

module alu_ctrl
  import alu_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  alu_ctrl_if.slave bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_instr;
  logic [C_DATA_W-1:0] r_alu_a;
  logic [C_DATA_W-1:0] r_alu_b;
  logic [1:0]          r_alu_sel;
  logic [C_DATA_W-1:0] r_res_data;
  logic [C_FLAG_W-1:0] r_res_flags;

  logic                w_instr_ready;
  logic                w_res_valid;
  logic                w_wb_en;
  logic [1:0]          w_op;
  logic [1:0]          w_rd;
  logic [1:0]          w_rs1;
  logic [1:0]          w_rs2;
  logic [C_DATA_W-1:0] w_rdata_a;
  logic [C_DATA_W-1:0] w_rdata_b;
  logic [1:0]          w_flags_base;
  logic [C_FLAG_W-1:0] w_flags_nxt;

  assign w_op  = r_instr[C_OP_LSB  +: 2];
  assign w_rd  = r_instr[C_RD_LSB  +: 2];
  assign w_rs1 = r_instr[C_RS1_LSB +: 2];
  assign w_rs2 = r_instr[C_RS2_LSB +: 2];

  alu_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_wb_en   (w_wb_en),
    .i_wb_addr (w_rd),
    .i_wb_data (bus.alu_y),
    .i_ld_en   (bus.ld_valid),
    .i_ld_addr (bus.ld_addr),
    .i_ld_data (bus.ld_data),
    .i_ra_addr (w_rs1),
    .o_ra_data (w_rdata_a),
    .i_rb_addr (w_rs2),
    .o_rb_data (w_rdata_b)
  );

  assign w_flags_base = mask_flags(r_alu_sel, bus.alu_ovf, bus.alu_brw);

`ifdef ALU_CTRL_ZFLAG_EN
  assign w_flags_nxt = {(bus.alu_y == '0), w_flags_base};
`else
  assign w_flags_nxt = w_flags_base;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_instr_ready = 1'b0;
    w_res_valid   = 1'b0;
    w_wb_en       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_instr_ready = 1'b1;
        if (bus.instr_valid) w_state_nxt = ST_OPRD;
      end
      ST_OPRD: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        w_wb_en     = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_res_valid = 1'b1;
        if (bus.res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operands are latched in OPRD so the ALU sees stable inputs through EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_res_data  <= '0;
      r_res_flags <= '0;
    end else begin
      if ((r_state == ST_IDLE) && bus.instr_valid) begin
        r_instr <= bus.instr;
      end
      if (r_state == ST_OPRD) begin
        r_alu_a   <= w_rdata_a;
        r_alu_b   <= w_rdata_b;
        r_alu_sel <= w_op;
      end
      if (r_state == ST_EXEC) begin
        r_res_data  <= bus.alu_y;
        r_res_flags <= w_flags_nxt;
      end
    end
  end

  assign bus.instr_ready = w_instr_ready;
  assign bus.res_valid   = w_res_valid;
  assign bus.res_data    = r_res_data;
  assign bus.res_flags   = r_res_flags;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_sel     = r_alu_sel;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed vector table plus hand sequences for stall, reset and
// writeback/preload collision, with a reference ALU driving the ALU inputs.
`default_nettype none

module tb_alu_ctrl;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_ctrl_if bus ();

  alu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: raw carry and borrow are always driven so masking is exercised.
  logic [8:0] w_sum9;
  assign w_sum9      = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.alu_ovf = w_sum9[8];
  assign bus.alu_brw = (bus.alu_a < bus.alu_b);
  always_comb begin
    bus.alu_y = 8'h00;
    case (bus.alu_sel)
      2'b00: bus.alu_y = bus.alu_a + bus.alu_b;
      2'b01: bus.alu_y = bus.alu_a - bus.alu_b;
      2'b10: bus.alu_y = bus.alu_a & bus.alu_b;
      default: bus.alu_y = bus.alu_a | bus.alu_b;
    endcase
  end

  typedef struct {
    logic [7:0] r1;
    logic [7:0] r2;
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [7:0] y;
    logic       ovf;
    logic       brw;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [C_FLAG_W-1:0] exp_flags(input logic [7:0] y,
                                                    input logic ovf,
                                                    input logic brw);
`ifdef ALU_CTRL_ZFLAG_EN
    return {(y == 8'h00), brw, ovf};
`else
    return {brw, ovf};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
  endtask

  // Returns cycles from acceptance edge until res_valid is observed (2 = N+2..N+3).
  task automatic issue(input logic [7:0] ins, output int lat);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic readback(input string name, input logic [1:0] addr, input logic [7:0] exp);
    int lat;
    issue({2'b11, addr, addr, addr}, lat);
    chk({name, "_lat"}, lat, 2);
    chk(name, bus.res_data, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    logic [7:0] ea;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    bus.ld_valid    = 1'b0;
    bus.ld_addr     = 2'd0;
    bus.ld_data     = 8'h00;
    bus.res_ready   = 1'b1;

    vecs[0] = '{8'hF0, 8'h20, 2'b00, 2'd3, 2'd1, 2'd2, 8'h10, 1'b1, 1'b0};
    vecs[1] = '{8'h05, 8'h07, 2'b01, 2'd0, 2'd1, 2'd2, 8'hFE, 1'b0, 1'b1};
    vecs[2] = '{8'hCC, 8'hAA, 2'b10, 2'd0, 2'd1, 2'd2, 8'h88, 1'b0, 1'b0};
    vecs[3] = '{8'hCC, 8'hAA, 2'b11, 2'd0, 2'd2, 2'd1, 8'hEE, 1'b0, 1'b0};
    vecs[4] = '{8'h05, 8'h07, 2'b01, 2'd0, 2'd1, 2'd1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 8'h02, 2'b00, 2'd1, 2'd1, 2'd2, 8'h03, 1'b0, 1'b0};
    vecs[6] = '{8'h90, 8'h80, 2'b01, 2'd2, 2'd1, 2'd2, 8'h10, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_instr_ready", bus.instr_ready, 1);
    chk("rst_res_valid",   bus.res_valid,   0);
    chk("rst_res_data",    bus.res_data,    0);
    chk("rst_res_flags",   bus.res_flags,   0);
    chk("rst_alu_a",       bus.alu_a,       0);
    chk("rst_alu_b",       bus.alu_b,       0);
    chk("rst_alu_sel",     bus.alu_sel,     0);
    readback("rst_r2", 2'd2, 8'h00);

    for (int i = 0; i < 7; i++) begin
      preload(2'd1, vecs[i].r1);
      preload(2'd2, vecs[i].r2);
      issue({vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2}, lat);
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_data", i), bus.res_data, vecs[i].y);
      chk($sformatf("v%0d_flags", i), bus.res_flags,
          exp_flags(vecs[i].y, vecs[i].ovf, vecs[i].brw));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle_ready", i), bus.instr_ready, 1);
      chk($sformatf("v%0d_idle_valid", i), bus.res_valid, 0);
      ea = (vecs[i].rs1 == 2'd1) ? vecs[i].r1 : vecs[i].r2;
      chk($sformatf("v%0d_alu_a_hold", i), bus.alu_a, ea);
      chk($sformatf("v%0d_alu_sel_hold", i), bus.alu_sel, vecs[i].op);
      readback($sformatf("v%0d_rd", i), vecs[i].rd, vecs[i].y);
    end

    // Stall in DONE while a competing instruction is presented.
    preload(2'd1, 8'hCC);
    preload(2'd2, 8'hAA);
    bus.res_ready = 1'b0;
    issue({2'b10, 2'd3, 2'd1, 2'd2}, lat);
    chk("stall_latency", lat, 2);
    bus.instr_valid = 1'b1;
    bus.instr       = {2'b11, 2'd3, 2'd1, 2'd2};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), bus.res_valid, 1);
      chk($sformatf("stall%0d_data", k), bus.res_data, 8'h88);
      chk($sformatf("stall%0d_ready", k), bus.instr_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.instr_valid = 1'b0;
    bus.res_ready   = 1'b1;
    chk("stall_release_valid", bus.res_valid, 1);
    @(posedge clk);
    #1;
    chk("stall_after_valid", bus.res_valid, 0);
    @(posedge clk);
    #1;
    chk("stall_ignored_sel", bus.alu_sel, 2'b10);
    readback("stall_r3", 2'd3, 8'h88);

    // Writeback and preload to the same register in the EXEC cycle.
    preload(2'd1, 8'hF0);
    preload(2'd2, 8'h20);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = {2'b00, 2'd3, 2'd1, 2'd2};
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    chk("coll_oprd_ready", bus.instr_ready, 0);
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 2'd3;
    bus.ld_data  = 8'h55;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    chk("coll_valid", bus.res_valid, 1);
    chk("coll_data", bus.res_data, 8'h10);
    @(posedge clk);
    #1;
    readback("coll_r3", 2'd3, 8'h10);

    // Reset during EXEC abandons the instruction.
    preload(2'd3, 8'h77);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = {2'b00, 2'd3, 2'd1, 2'd2};
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.res_valid, 0);
    chk("mid_rst_data",  bus.res_data,  0);
    chk("mid_rst_flags", bus.res_flags, 0);
    chk("mid_rst_alu_a", bus.alu_a,     0);
    chk("mid_rst_alu_b", bus.alu_b,     0);
    chk("mid_rst_sel",   bus.alu_sel,   0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_valid", k), bus.res_valid, 0);
      chk($sformatf("post_rst%0d_ready", k), bus.instr_ready, 1);
    end
    readback("post_rst_r3", 2'd3, 8'h00);
    readback("post_rst_r1", 2'd1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
